// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer
// Purpose  : Multi-cycle stage sequencer (IDLE/STEP/WAIT) with stall, flush,
//            sticky halt and an optional retired-instruction counter
//            (enabled by defining SEQ_PERF_CNT_EN).
// Revision : 1.0
// ============================================================================
module multicycle_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int MEM_STAGE  = 3,
  parameter int MEM_WAIT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  stall,
  input  logic                  flush,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [2:0]            stage_idx,
  output logic                  instr_done,
  output logic                  busy,
  output logic [CNT_W-1:0]      instr_count
);

  localparam logic [2:0]            LAST_IDX = 3'(NUM_STAGES - 1);
  localparam logic [2:0]            MEM_IDX  = 3'(MEM_STAGE);
  localparam logic [3:0]            WAIT_LD  = 4'(MEM_WAIT);
  localparam bit                    HAS_WAIT = (MEM_WAIT > 0);
  localparam logic [NUM_STAGES-1:0] EN_ONE   = NUM_STAGES'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                state_q;
  logic [2:0]            idx_q;
  logic [NUM_STAGES-1:0] en_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  halt_pend_q;
  logic [3:0]            wait_q;

  logic                  halt_d;
  logic                  last_d;
  logic [2:0]            next_idx_d;
  logic                  wrap_idle_d;

  // A halt raised in the final busy cycle still counts at that boundary.
  assign halt_d      = halt_pend_q | halt_req;
  assign last_d      = (idx_q == LAST_IDX);
  assign next_idx_d  = last_d ? 3'd0 : (idx_q + 3'd1);
  assign wrap_idle_d = last_d & halt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      en_q        <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      wait_q      <= 4'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_STEP;
            idx_q   <= 3'd0;
            en_q    <= EN_ONE;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            wait_q  <= 4'd0;
          end
        end

        S_STEP, S_WAIT: begin
          if (halt_req) begin
            halt_pend_q <= 1'b1;
          end
          if (flush) begin
            if (halt_d) begin
              state_q     <= S_IDLE;
              idx_q       <= 3'd0;
              en_q        <= '0;
              done_q      <= 1'b0;
              busy_q      <= 1'b0;
              halt_pend_q <= 1'b0;
              wait_q      <= 4'd0;
            end else begin
              state_q <= S_STEP;
              idx_q   <= 3'd0;
              en_q    <= EN_ONE;
              done_q  <= 1'b0;
              wait_q  <= 4'd0;
            end
          end else if (stall) begin
            state_q <= state_q;
          end else if ((state_q == S_STEP) && HAS_WAIT && (idx_q == MEM_IDX)) begin
            state_q <= S_WAIT;
            en_q    <= '0;
            done_q  <= 1'b0;
            wait_q  <= WAIT_LD;
          end else if ((state_q == S_WAIT) && (wait_q > 4'd1)) begin
            wait_q <= wait_q - 4'd1;
          end else if (wrap_idle_d) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            en_q        <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            halt_pend_q <= 1'b0;
            wait_q      <= 4'd0;
          end else begin
            state_q <= S_STEP;
            idx_q   <= next_idx_d;
            en_q    <= EN_ONE << next_idx_d;
            done_q  <= (next_idx_d == LAST_IDX);
            wait_q  <= 4'd0;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          idx_q       <= 3'd0;
          en_q        <= '0;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          halt_pend_q <= 1'b0;
          wait_q      <= 4'd0;
        end
      endcase
    end
  end

  // Stall masks the registered pulse in its own cycle; flush outranks stall
  // so the enable still shows, but a flushed or stalled last stage never retires.
  assign stage_en   = en_q & {NUM_STAGES{flush | ~stall}};
  assign instr_done = done_q & ~flush & ~stall;
  assign stage_idx  = idx_q;
  assign busy       = busy_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (instr_done) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// Directed bench for multicycle_sequencer: default build plus a MEM_WAIT=0 copy.
module tb_multicycle_sequencer;

  localparam int NS = 5;
  localparam int CW = 3;
`ifdef SEQ_PERF_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          halt_req;
  logic          stall;
  logic          flush;
  logic [NS-1:0] stage_en,    stage_en0;
  logic [2:0]    stage_idx,   stage_idx0;
  logic          instr_done,  instr_done0;
  logic          busy,        busy0;
  logic [CW-1:0] instr_count, instr_count0;

  int checks    = 0;
  int errors    = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .NUM_STAGES(NS), .MEM_STAGE(3), .MEM_WAIT(1), .CNT_W(CW)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .stall(stall), .flush(flush), .stage_en(stage_en), .stage_idx(stage_idx),
    .instr_done(instr_done), .busy(busy), .instr_count(instr_count)
  );

  multicycle_sequencer #(
    .NUM_STAGES(NS), .MEM_STAGE(3), .MEM_WAIT(0), .CNT_W(CW)
  ) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .stall(stall), .flush(flush), .stage_en(stage_en0), .stage_idx(stage_idx0),
    .instr_done(instr_done0), .busy(busy0), .instr_count(instr_count0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp();
    return (CNT_ON != 0) ? 32'(exp_count % 8) : 32'd0;
  endfunction

  task automatic cy(input string tag, input logic s, input logic h, input logic st,
                    input logic fl, input logic [NS-1:0] en, input logic [2:0] idx,
                    input logic dn, input logic bz);
    @(negedge clk);
    start = s; halt_req = h; stall = st; flush = fl;
    #1;
    chk({tag, ".en"},   32'(stage_en),    32'(en));
    chk({tag, ".idx"},  32'(stage_idx),   32'(idx));
    chk({tag, ".done"}, 32'(instr_done),  32'(dn));
    chk({tag, ".busy"}, 32'(busy),        32'(bz));
    chk({tag, ".cnt"},  32'(instr_count), cnt_exp());
    if (dn) exp_count++;
  endtask

  task automatic chk0(input string tag, input logic [NS-1:0] en, input logic [2:0] idx,
                      input logic dn);
    chk({tag, ".w0en"},   32'(stage_en0),   32'(en));
    chk({tag, ".w0idx"},  32'(stage_idx0),  32'(idx));
    chk({tag, ".w0done"}, 32'(instr_done0), 32'(dn));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NS-1:0] seq_en  [6] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h00, 5'h10};
    logic [2:0]    seq_idx [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4};

    reset = 1'b1; start = 1'b0; halt_req = 1'b0; stall = 1'b0; flush = 1'b0;
    @(negedge clk); #1;
    chk("rst.en",   32'(stage_en),    32'd0);
    chk("rst.idx",  32'(stage_idx),   32'd0);
    chk("rst.done", 32'(instr_done),  32'd0);
    chk("rst.busy", 32'(busy),        32'd0);
    chk("rst.cnt",  32'(instr_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // A: plain run, start ignored while busy, halt during second instruction
    cy("A0",  1, 0, 0, 0, 5'h00, 3'd0, 0, 0);
    cy("A1",  0, 0, 0, 0, 5'h01, 3'd0, 0, 1); chk0("A1", 5'h01, 3'd0, 0);
    cy("A2",  0, 0, 0, 0, 5'h02, 3'd1, 0, 1); chk0("A2", 5'h02, 3'd1, 0);
    cy("A3",  1, 0, 0, 0, 5'h04, 3'd2, 0, 1); chk0("A3", 5'h04, 3'd2, 0);
    cy("A4",  0, 0, 0, 0, 5'h08, 3'd3, 0, 1); chk0("A4", 5'h08, 3'd3, 0);
    cy("A5",  0, 0, 0, 0, 5'h00, 3'd3, 0, 1); chk0("A5", 5'h10, 3'd4, 1);
    cy("A6",  0, 0, 0, 0, 5'h10, 3'd4, 1, 1); chk0("A6", 5'h01, 3'd0, 0);
    cy("A7",  0, 1, 0, 0, 5'h01, 3'd0, 0, 1); chk0("A7", 5'h02, 3'd1, 0);
    chk("A7.w0cnt", 32'(instr_count0), 32'(CNT_ON));
    cy("A8",  0, 0, 0, 0, 5'h02, 3'd1, 0, 1);
    cy("A9",  0, 0, 0, 0, 5'h04, 3'd2, 0, 1);
    cy("A10", 0, 0, 0, 0, 5'h08, 3'd3, 0, 1);
    cy("A11", 0, 0, 0, 0, 5'h00, 3'd3, 0, 1);
    cy("A12", 0, 0, 0, 0, 5'h10, 3'd4, 1, 1);
    cy("A13", 0, 0, 0, 0, 5'h00, 3'd0, 0, 0);
    cy("A14", 0, 0, 0, 0, 5'h00, 3'd0, 0, 0);

    // B: stall at cycles 2-3
    cy("B0", 1, 0, 0, 0, 5'h00, 3'd0, 0, 0);
    cy("B1", 0, 0, 0, 0, 5'h01, 3'd0, 0, 1);
    cy("B2", 0, 0, 1, 0, 5'h00, 3'd1, 0, 1);
    cy("B3", 0, 0, 1, 0, 5'h00, 3'd1, 0, 1);
    cy("B4", 0, 0, 0, 0, 5'h02, 3'd1, 0, 1);
    cy("B5", 0, 1, 0, 0, 5'h04, 3'd2, 0, 1);
    cy("B6", 0, 0, 0, 0, 5'h08, 3'd3, 0, 1);
    cy("B7", 0, 0, 0, 0, 5'h00, 3'd3, 0, 1);
    cy("B8", 0, 0, 0, 0, 5'h10, 3'd4, 1, 1);
    cy("B9", 0, 0, 0, 0, 5'h00, 3'd0, 0, 0);

    // C: flush at cycle 3, flush+stall on last stage, flush with halt pending
    cy("C0",  1, 0, 0, 0, 5'h00, 3'd0, 0, 0);
    cy("C1",  0, 0, 0, 0, 5'h01, 3'd0, 0, 1);
    cy("C2",  0, 0, 0, 0, 5'h02, 3'd1, 0, 1);
    cy("C3",  0, 0, 0, 1, 5'h04, 3'd2, 0, 1);
    cy("C4",  0, 0, 0, 0, 5'h01, 3'd0, 0, 1);
    cy("C5",  0, 0, 0, 0, 5'h02, 3'd1, 0, 1);
    cy("C6",  0, 0, 0, 0, 5'h04, 3'd2, 0, 1);
    cy("C7",  0, 0, 0, 0, 5'h08, 3'd3, 0, 1);
    cy("C8",  0, 0, 0, 0, 5'h00, 3'd3, 0, 1);
    cy("C9",  0, 0, 1, 1, 5'h10, 3'd4, 0, 1);
    cy("C10", 0, 1, 0, 0, 5'h01, 3'd0, 0, 1);
    cy("C11", 0, 0, 0, 1, 5'h02, 3'd1, 0, 1);
    cy("C12", 0, 0, 0, 0, 5'h00, 3'd0, 0, 0);

    // D: halt at cycle 2, then control inputs in IDLE
    cy("D0", 1, 0, 0, 0, 5'h00, 3'd0, 0, 0);
    cy("D1", 0, 0, 0, 0, 5'h01, 3'd0, 0, 1);
    cy("D2", 0, 1, 0, 0, 5'h02, 3'd1, 0, 1);
    cy("D3", 0, 0, 0, 0, 5'h04, 3'd2, 0, 1);
    cy("D4", 0, 0, 0, 0, 5'h08, 3'd3, 0, 1);
    cy("D5", 0, 0, 0, 0, 5'h00, 3'd3, 0, 1);
    cy("D6", 0, 0, 0, 0, 5'h10, 3'd4, 1, 1);
    cy("D7", 0, 1, 1, 1, 5'h00, 3'd0, 0, 0);
    cy("D8", 0, 0, 0, 0, 5'h00, 3'd0, 0, 0);

    // E: stall in WAIT, stall on last stage, flush in WAIT
    cy("E0",  1, 0, 0, 0, 5'h00, 3'd0, 0, 0);
    cy("E1",  0, 0, 0, 0, 5'h01, 3'd0, 0, 1);
    cy("E2",  0, 0, 0, 0, 5'h02, 3'd1, 0, 1);
    cy("E3",  0, 0, 0, 0, 5'h04, 3'd2, 0, 1);
    cy("E4",  0, 0, 0, 0, 5'h08, 3'd3, 0, 1);
    cy("E5",  0, 0, 1, 0, 5'h00, 3'd3, 0, 1);
    cy("E6",  0, 0, 0, 0, 5'h00, 3'd3, 0, 1);
    cy("E7",  0, 0, 1, 0, 5'h00, 3'd4, 0, 1);
    cy("E8",  0, 0, 0, 0, 5'h10, 3'd4, 1, 1);
    cy("E9",  0, 0, 0, 0, 5'h01, 3'd0, 0, 1);
    cy("E10", 0, 0, 0, 0, 5'h02, 3'd1, 0, 1);
    cy("E11", 0, 0, 0, 0, 5'h04, 3'd2, 0, 1);
    cy("E12", 0, 0, 0, 0, 5'h08, 3'd3, 0, 1);
    cy("E13", 0, 0, 0, 1, 5'h00, 3'd3, 0, 1);
    cy("E14", 0, 1, 0, 0, 5'h01, 3'd0, 0, 1);
    cy("E15", 0, 0, 0, 0, 5'h02, 3'd1, 0, 1);
    cy("E16", 0, 0, 0, 0, 5'h04, 3'd2, 0, 1);
    cy("E17", 0, 0, 0, 0, 5'h08, 3'd3, 0, 1);
    cy("E18", 0, 0, 0, 0, 5'h00, 3'd3, 0, 1);
    cy("E19", 0, 0, 0, 0, 5'h10, 3'd4, 1, 1);
    cy("E20", 0, 0, 0, 0, 5'h00, 3'd0, 0, 0);

    // F: asynchronous reset at stage 3, start held during reset
    cy("F0", 1, 0, 0, 0, 5'h00, 3'd0, 0, 0);
    cy("F1", 0, 0, 0, 0, 5'h01, 3'd0, 0, 1);
    cy("F2", 0, 0, 0, 0, 5'h02, 3'd1, 0, 1);
    cy("F3", 0, 0, 0, 0, 5'h04, 3'd2, 0, 1);
    cy("F4", 0, 0, 0, 0, 5'h08, 3'd3, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    exp_count = 0;
    chk("F.rst.en",   32'(stage_en),    32'd0);
    chk("F.rst.idx",  32'(stage_idx),   32'd0);
    chk("F.rst.done", 32'(instr_done),  32'd0);
    chk("F.rst.busy", 32'(busy),        32'd0);
    chk("F.rst.cnt",  32'(instr_count), 32'd0);
    start = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("F.hold.en",   32'(stage_en), 32'd0);
    chk("F.hold.busy", 32'(busy),     32'd0);
    reset = 1'b0;
    start = 1'b0;
    cy("F5", 0, 0, 0, 0, 5'h00, 3'd0, 0, 0);
    cy("F6", 0, 0, 0, 0, 5'h00, 3'd0, 0, 0);

    // G: nine retired instructions, halt during the ninth
    cy("G0", 1, 0, 0, 0, 5'h00, 3'd0, 0, 0);
    for (int n = 0; n < 9; n++) begin
      for (int k = 0; k < 6; k++) begin
        cy($sformatf("G%0d_%0d", n, k), 0, (n == 8 && k == 0), 0, 0,
           seq_en[k], seq_idx[k], (k == 5), 1);
      end
    end
    cy("G_end", 0, 0, 0, 0, 5'h00, 3'd0, 0, 0);
    chk("G.final_cnt", 32'(instr_count), 32'(CNT_ON));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 5, SHALL give the number of pipeline phases (legal 2..8).
REQ-002 Parameter MEM_STAGE, default 3, SHALL give the stage index that may insert wait cycles (0..NUM_STAGES-1).
REQ-003 Parameter MEM_WAIT, default 1, SHALL give the extra hold cycles after MEM_STAGE's enable (legal 0..15).
REQ-004 Parameter CNT_W, default 32, SHALL give the width of instr_count.
REQ-005 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-007 start  in  1  SHALL be a request to begin sequencing from IDLE.
REQ-008 halt_req  in  1  SHALL be a request to stop at the next instruction boundary.
REQ-009 stall  in  1  SHALL be a request to freeze the current stage.
REQ-010 flush  in  1  SHALL be a request to abort the current instruction (taken branch).
REQ-011 stage_en  out  NUM_STAGES  SHALL be the registered one-hot stage enable, or all-zero.
REQ-012 stage_idx  out  3  SHALL be the registered current stage index.
REQ-013 instr_done  out  1  SHALL be a one-cycle pulse marking instruction completion.
REQ-014 busy  out  1  SHALL be high in every state except IDLE.
REQ-015 instr_count  out  CNT_W  SHALL be the retired-instruction count (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, STEP and WAIT.
REQ-017 IDLE with start=1 SHALL enter STEP next cycle with stage_idx=0, stage_en=1, busy=1: latency 1 cycle.
REQ-018 start while busy SHALL be ignored; halt_req, stall and flush in IDLE SHALL be ignored.
REQ-019 STEP with stall=0 SHALL assert stage_en bit stage_idx for exactly one cycle, then advance stage_idx by 1.
REQ-020 On entering stage MEM_STAGE with MEM_WAIT>0, the FSM SHALL pulse stage_en once, then hold WAIT for MEM_WAIT cycles with stage_en=0, then advance.
REQ-021 With MEM_WAIT=0, no WAIT state SHALL be entered; each instruction SHALL take NUM_STAGES+MEM_WAIT cycles absent stall/flush.
REQ-022 stall=1 SHALL force stage_en=0, freeze stage_idx and the wait counter, and resume the same stage (re-pulsing its enable) on the first cycle stall=0.
REQ-023 instr_done SHALL pulse in the same cycle as stage_en[NUM_STAGES-1]; the next cycle SHALL wrap to stage 0 unless a halt is pending.
REQ-024 halt_req=1 in any busy cycle SHALL set a sticky pending-halt flag; at the wrap the FSM SHALL enter IDLE with stage_en=0 and busy=0, and clear the flag.
REQ-025 flush=1 in STEP or WAIT SHALL return to stage 0 next cycle with no instr_done pulse; with a halt pending it SHALL enter IDLE instead.
REQ-026 Priority SHALL be reset > flush > stall > normal advance.
REQ-027 flush coinciding with the last stage SHALL suppress that cycle's instr_done; stage_en[NUM_STAGES-1] still pulses.

Reset
REQ-028 reset=1 SHALL immediately force IDLE, stage_en=0, stage_idx=0, instr_done=0, busy=0, instr_count=0, and clear the pending-halt flag and wait counter.
REQ-029 reset asserted mid-instruction SHALL discard it without an instr_done pulse; after release, start is required to resume.

Configuration
REQ-030 With macro SEQ_PERF_CNT_EN defined, instr_count SHALL increment by 1 on each instr_done and wrap from 2^CNT_W-1 to 0.
REQ-031 Without SEQ_PERF_CNT_EN, instr_count SHALL be tied to 0 and no counter logic SHALL be synthesised.

Verification
REQ-032 Defaults, start pulse at cycle 0 -> stage_en 01,02,04,08,00,10 at cycles 1-6; instr_done at cycle 6; stage_en=01 again at cycle 7.
REQ-033 stall high at cycles 2-3 -> stage_en=0 at cycles 2-3, stage_en=02 at cycle 4, instr_done at cycle 8.
REQ-034 flush at cycle 3 -> stage_en=01 at cycle 4, no instr_done through cycle 6, instr_done at cycle 9.
REQ-035 halt_req pulsed at cycle 2 -> instr_done at cycle 6; busy=0 and stage_en=0 from cycle 7.
REQ-036 reset asserted mid-cycle at stage 3 -> outputs zero immediately without a clock edge; start ignored until reset deasserts.
REQ-037 SEQ_PERF_CNT_EN, CNT_W=3, 9 completed instructions -> instr_count=1 (wrapped); without the macro -> instr_count=0 throughout.
